// File: rtl/jump_target_unit_if.sv
// Decode-to-fetch bundle for the jump target unit: request, label-table write and resolved target.
// The decode side drives the request and table write; the unit returns the target and status.
interface jump_target_unit_if #(
  parameter int ADDR_W      = 16,
  parameter int DEPTH       = 16,
  parameter int IDX_W       = $clog2(DEPTH),
  parameter int STACK_DEPTH = 4
);
  localparam int LVL_W = $clog2(STACK_DEPTH + 1);

  logic              req_valid;
  logic [1:0]        req_mode;
  logic [ADDR_W-1:0] direct_addr;
  logic [IDX_W-1:0]  label_idx;
  logic [ADDR_W-1:0] ret_addr;
  logic              tbl_we;
  logic [IDX_W-1:0]  tbl_waddr;
  logic [ADDR_W-1:0] tbl_wdata;
  logic              tgt_valid;
  logic [ADDR_W-1:0] tgt_addr;
  logic              err_overflow;
  logic              err_underflw;
  logic [LVL_W-1:0]  stack_level;

  modport master (
    output req_valid, req_mode, direct_addr, label_idx, ret_addr,
    output tbl_we, tbl_waddr, tbl_wdata,
    input  tgt_valid, tgt_addr, err_overflow, err_underflw, stack_level
  );

  modport slave (
    input  req_valid, req_mode, direct_addr, label_idx, ret_addr,
    input  tbl_we, tbl_waddr, tbl_wdata,
    output tgt_valid, tgt_addr, err_overflow, err_underflw, stack_level
  );
endinterface

// File: rtl/jump_target_unit.sv
// Next-PC target resolver: direct, label-table, call (push) and return (pop) modes.
// Latency 1 cycle (registered strobe); no backpressure, one request accepted every cycle.
module jump_target_unit #(
  parameter int ADDR_W      = 16,
  parameter int DEPTH       = 16,
  parameter int IDX_W       = $clog2(DEPTH),
  parameter int STACK_DEPTH = 4
) (
  input logic               clk,
  input logic               rst_n,
  jump_target_unit_if.slave bus
);
  localparam int LVL_W = $clog2(STACK_DEPTH + 1);
  localparam int SP_W  = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam int SLOTS = 1 << SP_W;
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(STACK_DEPTH);

  localparam logic [1:0] MODE_DIRECT = 2'b00;
  localparam logic [1:0] MODE_LABEL  = 2'b01;
  localparam logic [1:0] MODE_CALL   = 2'b10;
  localparam logic [1:0] MODE_RET    = 2'b11;

  function automatic logic [ADDR_W-1:0] tbl_default(input int i);
    int v;
    case (i)
      0: v = 10;
      1: v = 22;
      2: v = 76;
      3: v = 101;
      4: v = 118;
      5: v = 124;
      6: v = 8;
      7: v = 37;
      8: v = 16;
      default: v = 0;
    endcase
    return ADDR_W'(v);
  endfunction

  logic [ADDR_W-1:0] tbl_q [DEPTH];
  logic [ADDR_W-1:0] stk_q [SLOTS];
  logic [LVL_W-1:0]  level_q, level_d;
  logic              tgt_valid_q, tgt_valid_d;
  logic [ADDR_W-1:0] tgt_addr_q, tgt_addr_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;
  logic              push_en;
  logic [ADDR_W-1:0] label_val;
  logic [SP_W-1:0]   push_idx;
  logic [SP_W-1:0]   pop_idx;

  // A same-cycle write to the index being read wins over the stored entry.
  assign label_val = (bus.tbl_we && (bus.tbl_waddr == bus.label_idx)) ?
                     bus.tbl_wdata : tbl_q[bus.label_idx];
  assign push_idx  = SP_W'(level_q);
  assign pop_idx   = SP_W'(level_q - 1'b1);

  always_comb begin
    tgt_valid_d = 1'b0;
    tgt_addr_d  = tgt_addr_q;
    ovf_d       = 1'b0;
    unf_d       = 1'b0;
    level_d     = level_q;
    push_en     = 1'b0;
    if (bus.req_valid) begin
      case (bus.req_mode)
        MODE_DIRECT: begin
          tgt_valid_d = 1'b1;
          tgt_addr_d  = bus.direct_addr;
        end
        MODE_LABEL: begin
          tgt_valid_d = 1'b1;
          tgt_addr_d  = label_val;
        end
        MODE_CALL: begin
          tgt_valid_d = 1'b1;
          tgt_addr_d  = label_val;
          if (level_q == LVL_FULL) begin
            ovf_d = 1'b1;
          end else begin
            push_en = 1'b1;
            level_d = level_q + 1'b1;
          end
        end
        MODE_RET: begin
          if (level_q == '0) begin
            unf_d = 1'b1;
          end else begin
            tgt_valid_d = 1'b1;
            tgt_addr_d  = stk_q[pop_idx];
            level_d     = level_q - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tgt_valid_q <= 1'b0;
      tgt_addr_q  <= '0;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
      level_q     <= '0;
    end else begin
      tgt_valid_q <= tgt_valid_d;
      tgt_addr_q  <= tgt_addr_d;
      ovf_q       <= ovf_d;
      unf_q       <= unf_d;
      level_q     <= level_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) tbl_q[i] <= tbl_default(i);
    end else if (bus.tbl_we) begin
      tbl_q[bus.tbl_waddr] <= bus.tbl_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SLOTS; i++) stk_q[i] <= '0;
    end else if (push_en) begin
      stk_q[push_idx] <= bus.ret_addr;
    end
  end

  assign bus.tgt_valid    = tgt_valid_q;
  assign bus.tgt_addr     = tgt_addr_q;
  assign bus.err_overflow = ovf_q;
  assign bus.err_underflw = unf_q;
  assign bus.stack_level  = level_q;
endmodule

// File: tb/tb_jump_target_unit.sv
// Directed bench for jump_target_unit: expected outputs are queued when a request is driven
// and compared one cycle later when the registered result appears.
module tb_jump_target_unit;
  localparam logic [1:0] M_DIR = 2'b00;
  localparam logic [1:0] M_LBL = 2'b01;
  localparam logic [1:0] M_CALL = 2'b10;
  localparam logic [1:0] M_RET = 2'b11;

  typedef struct packed {
    logic        v;
    logic [15:0] a;
    logic        o;
    logic        u;
    logic [2:0]  l;
  } exp_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  exp_t sb[$];

  jump_target_unit_if #(.ADDR_W(16), .DEPTH(16), .STACK_DEPTH(4)) bus ();

  jump_target_unit #(.ADDR_W(16), .DEPTH(16), .STACK_DEPTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_outputs(input string tag, input exp_t e);
    chk({tag, ".valid"}, 32'(bus.tgt_valid), 32'(e.v));
    chk({tag, ".addr"}, 32'(bus.tgt_addr), 32'(e.a));
    chk({tag, ".ovf"}, 32'(bus.err_overflow), 32'(e.o));
    chk({tag, ".unf"}, 32'(bus.err_underflw), 32'(e.u));
    chk({tag, ".level"}, 32'(bus.stack_level), 32'(e.l));
  endtask

  task automatic drive(input logic v, input logic [1:0] m, input logic [15:0] da,
                       input logic [3:0] idx, input logic [15:0] ra, input logic we,
                       input logic [3:0] wa, input logic [15:0] wd);
    bus.req_valid   = v;
    bus.req_mode    = m;
    bus.direct_addr = da;
    bus.label_idx   = idx;
    bus.ret_addr    = ra;
    bus.tbl_we      = we;
    bus.tbl_waddr   = wa;
    bus.tbl_wdata   = wd;
  endtask

  // Called at a falling edge: drive, queue the expectation, compare after the next rising edge.
  task automatic step(input string tag, input logic v, input logic [1:0] m,
                      input logic [15:0] da, input logic [3:0] idx, input logic [15:0] ra,
                      input logic we, input logic [3:0] wa, input logic [15:0] wd,
                      input logic ev, input logic [15:0] ea, input logic eo,
                      input logic eu, input logic [2:0] el);
    exp_t e;
    drive(v, m, da, idx, ra, we, wa, wd);
    e = '{v: ev, a: ea, o: eo, u: eu, l: el};
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s: scoreboard empty", tag);
    end else begin
      chk_outputs(tag, sb.pop_front());
    end
  endtask

  initial begin
    int lbl_exp [9];
    checks = 0;
    errors = 0;
    lbl_exp = '{10, 22, 76, 101, 118, 124, 8, 37, 16};
    rst_n = 1'b0;
    drive(1'b0, M_DIR, 16'h0, 4'h0, 16'h0, 1'b0, 4'h0, 16'h0);
    #12;
    chk_outputs("reset", '{v: 1'b0, a: 16'h0, o: 1'b0, u: 1'b0, l: 3'd0});
    @(negedge clk);
    rst_n = 1'b1;

    // T1: default label table
    for (int i = 0; i < 9; i++)
      step($sformatf("t1_label%0d", i), 1'b1, M_LBL, 16'h0, 4'(i), 16'h0, 1'b0, 4'h0, 16'h0,
           1'b1, 16'(lbl_exp[i]), 1'b0, 1'b0, 3'd0);

    // T2: direct, then idle holds the address
    step("t2_direct", 1'b1, M_DIR, 16'h1234, 4'h0, 16'h0, 1'b0, 4'h0, 16'h0,
         1'b1, 16'h1234, 1'b0, 1'b0, 3'd0);
    step("t2_idle", 1'b0, M_DIR, 16'h5555, 4'h0, 16'h0, 1'b0, 4'h0, 16'h0,
         1'b0, 16'h1234, 1'b0, 1'b0, 3'd0);

    // T3: write forwarding, plain write, write while idle
    step("t3_fwd", 1'b1, M_LBL, 16'h0, 4'd3, 16'h0, 1'b1, 4'd3, 16'h0200,
         1'b1, 16'h0200, 1'b0, 1'b0, 3'd0);
    step("t3_reread", 1'b1, M_LBL, 16'h0, 4'd3, 16'h0, 1'b0, 4'h0, 16'h0,
         1'b1, 16'h0200, 1'b0, 1'b0, 3'd0);
    step("t3_nofwd", 1'b1, M_LBL, 16'h0, 4'd4, 16'h0, 1'b1, 4'd5, 16'h0555,
         1'b1, 16'd118, 1'b0, 1'b0, 3'd0);
    step("t3_read5", 1'b1, M_LBL, 16'h0, 4'd5, 16'h0, 1'b0, 4'h0, 16'h0,
         1'b1, 16'h0555, 1'b0, 1'b0, 3'd0);
    step("t3_idlewr", 1'b0, M_LBL, 16'h0, 4'd0, 16'h0, 1'b1, 4'd6, 16'h0666,
         1'b0, 16'h0555, 1'b0, 1'b0, 3'd0);
    step("t3_read6", 1'b1, M_LBL, 16'h0, 4'd6, 16'h0, 1'b0, 4'h0, 16'h0,
         1'b1, 16'h0666, 1'b0, 1'b0, 3'd0);

    // T4: fill the stack, overflow, drain in LIFO order
    step("t4_call1", 1'b1, M_CALL, 16'h0, 4'd1, 16'h0011, 1'b0, 4'h0, 16'h0,
         1'b1, 16'd22, 1'b0, 1'b0, 3'd1);
    step("t4_call2", 1'b1, M_CALL, 16'h0, 4'd2, 16'h0012, 1'b0, 4'h0, 16'h0,
         1'b1, 16'd76, 1'b0, 1'b0, 3'd2);
    step("t4_call3", 1'b1, M_CALL, 16'h0, 4'd0, 16'h0013, 1'b0, 4'h0, 16'h0,
         1'b1, 16'd10, 1'b0, 1'b0, 3'd3);
    step("t4_call4", 1'b1, M_CALL, 16'h0, 4'd7, 16'h0014, 1'b0, 4'h0, 16'h0,
         1'b1, 16'd37, 1'b0, 1'b0, 3'd4);
    step("t4_ovf", 1'b1, M_CALL, 16'h0, 4'd8, 16'h0099, 1'b0, 4'h0, 16'h0,
         1'b1, 16'd16, 1'b1, 1'b0, 3'd4);
    step("t4_ret1", 1'b1, M_RET, 16'h0, 4'd0, 16'h0, 1'b0, 4'h0, 16'h0,
         1'b1, 16'h0014, 1'b0, 1'b0, 3'd3);
    step("t4_ret2", 1'b1, M_RET, 16'h0, 4'd0, 16'h0, 1'b0, 4'h0, 16'h0,
         1'b1, 16'h0013, 1'b0, 1'b0, 3'd2);
    step("t4_ret3", 1'b1, M_RET, 16'h0, 4'd0, 16'h0, 1'b0, 4'h0, 16'h0,
         1'b1, 16'h0012, 1'b0, 1'b0, 3'd1);
    step("t4_ret4", 1'b1, M_RET, 16'h0, 4'd0, 16'h0, 1'b0, 4'h0, 16'h0,
         1'b1, 16'h0011, 1'b0, 1'b0, 3'd0);

    // T5: underflow suppresses the strobe and holds the address
    step("t5_unf", 1'b1, M_RET, 16'h0, 4'd0, 16'h0, 1'b0, 4'h0, 16'h0,
         1'b0, 16'h0011, 1'b0, 1'b1, 3'd0);
    step("t5_idle", 1'b0, M_RET, 16'h0, 4'd0, 16'h0, 1'b0, 4'h0, 16'h0,
         1'b0, 16'h0011, 1'b0, 1'b0, 3'd0);

    // T6: asynchronous reset with a pending strobe and a modified table
    step("t6_call1", 1'b1, M_CALL, 16'h0, 4'd0, 16'h0021, 1'b0, 4'h0, 16'h0,
         1'b1, 16'd10, 1'b0, 1'b0, 3'd1);
    step("t6_call2", 1'b1, M_CALL, 16'h0, 4'd1, 16'h0022, 1'b1, 4'd3, 16'h0777,
         1'b1, 16'd22, 1'b0, 1'b0, 3'd2);
    #2;
    rst_n = 1'b0;
    #1;
    chk_outputs("t6_async", '{v: 1'b0, a: 16'h0, o: 1'b0, u: 1'b0, l: 3'd0});
    drive(1'b1, M_DIR, 16'hBEEF, 4'd0, 16'h0, 1'b0, 4'h0, 16'h0);
    @(negedge clk);
    chk_outputs("t6_held", '{v: 1'b0, a: 16'h0, o: 1'b0, u: 1'b0, l: 3'd0});
    drive(1'b0, M_DIR, 16'h0, 4'd0, 16'h0, 1'b0, 4'h0, 16'h0);
    rst_n = 1'b1;
    step("t6_lbl3", 1'b1, M_LBL, 16'h0, 4'd3, 16'h0, 1'b0, 4'h0, 16'h0,
         1'b1, 16'd101, 1'b0, 1'b0, 3'd0);
    step("t6_unf", 1'b1, M_RET, 16'h0, 4'd0, 16'h0, 1'b0, 4'h0, 16'h0,
         1'b0, 16'd101, 1'b0, 1'b1, 3'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
